// File: rtl/exibidor_sequencia.sv
// Plays the stored sequence back on the LEDs: each entry from address 0 to limite
// is lit for ON_CICLOS clocks, with OFF_CICLOS dark clocks between entries, then fim pulses.
module exibidor_sequencia #(
  parameter int unsigned ON_CICLOS    = 1000,
  parameter int unsigned OFF_CICLOS   = 500,
  parameter int unsigned LARGURA_CONT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic [3:0] limite,
  input  logic [3:0] dado_mem,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       fim,
  output logic [2:0] db_estado
);

  localparam int unsigned LARGURA_ESTADO = 3;
  localparam int unsigned LARGURA_END    = 4;

  localparam logic [LARGURA_ESTADO-1:0] OCIOSO  = 3'd0;
  localparam logic [LARGURA_ESTADO-1:0] ACESO   = 3'd1;
  localparam logic [LARGURA_ESTADO-1:0] APAGADO = 3'd2;
  localparam logic [LARGURA_ESTADO-1:0] FIM     = 3'd3;

  logic [LARGURA_ESTADO-1:0] estado, estado_prox;
  logic [LARGURA_CONT-1:0]   contador, contador_prox;
  logic [LARGURA_END-1:0]    endereco_prox;
  logic [3:0]                leds_prox;
  logic                      fim_aceso, fim_apagado;

  assign fim_aceso   = (contador == LARGURA_CONT'(ON_CICLOS - 1));
  assign fim_apagado = (contador == LARGURA_CONT'(OFF_CICLOS - 1));
  assign db_estado   = estado;

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= OCIOSO;
      contador <= '0;
      endereco <= '0;
      leds     <= '0;
      ocupado  <= 1'b0;
      fim      <= 1'b0;
    end else begin
      estado   <= estado_prox;
      contador <= contador_prox;
      endereco <= endereco_prox;
      leds     <= leds_prox;
      ocupado  <= (estado_prox != OCIOSO);
      fim      <= (estado_prox == FIM);
    end
  end

  // Next state; parar overrides both iniciar and the end-of-interval transitions
  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:  if (!parar && iniciar) estado_prox = ACESO;
      ACESO: begin
        if (parar)          estado_prox = OCIOSO;
        else if (fim_aceso) estado_prox = (endereco == limite) ? FIM : APAGADO;
      end
      APAGADO: begin
        if (parar)            estado_prox = OCIOSO;
        else if (fim_apagado) estado_prox = ACESO;
      end
      FIM:     estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

  // Datapath next values, keyed on the transition being taken
  always_comb begin
    leds_prox     = '0;
    endereco_prox = endereco;
    contador_prox = '0;
    case (estado_prox)
      ACESO: begin
        if (estado == ACESO) begin
          leds_prox     = leds;
          contador_prox = contador + LARGURA_CONT'(1);
        end else begin
          leds_prox     = dado_mem;
        end
      end
      APAGADO: begin
        if (estado == ACESO) endereco_prox = endereco + LARGURA_END'(1);
        else                 contador_prox = contador + LARGURA_CONT'(1);
      end
      FIM:     endereco_prox = endereco;
      default: endereco_prox = '0;
    endcase
  end

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Self-checking bench: expected LED/address/status trace per cycle is built from the
// playback rules (ON lit cycles per entry, OFF dark cycles between, then one fim cycle).
module tb_exibidor_sequencia;

  localparam int unsigned ON  = 3;
  localparam int unsigned OFF = 2;

  logic       clock = 1'b0;
  logic       reset, iniciar, parar;
  logic [3:0] limite;
  logic [3:0] dado_mem, endereco, leds;
  logic       ocupado, fim;
  logic [2:0] db_estado;

  logic [3:0]  mem [16];
  logic [12:0] exp_q [$];
  logic [12:0] obs;
  int checks = 0;
  int errors = 0;

  exibidor_sequencia #(.ON_CICLOS(ON), .OFF_CICLOS(OFF), .LARGURA_CONT(8)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .parar(parar),
    .limite(limite), .dado_mem(dado_mem), .endereco(endereco), .leds(leds),
    .ocupado(ocupado), .fim(fim), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  assign dado_mem = mem[endereco];
  assign obs      = {leds, endereco, ocupado, fim, db_estado};

  // Expected {leds, endereco, ocupado, fim, state} for each cycle after the iniciar edge
  function automatic void build(input int lim);
    exp_q.delete();
    for (int i = 0; i <= lim; i++) begin
      repeat (ON) exp_q.push_back({mem[i], 4'(i), 1'b1, 1'b0, 3'd1});
      if (i < lim) repeat (OFF) exp_q.push_back({4'b0, 4'(i + 1), 1'b1, 1'b0, 3'd2});
    end
    exp_q.push_back({4'b0, 4'(lim), 1'b1, 1'b1, 3'd3});
    exp_q.push_back({4'b0, 4'd0, 1'b0, 1'b0, 3'd0});
    exp_q.push_back({4'b0, 4'd0, 1'b0, 1'b0, 3'd0});
  endfunction

  task automatic start();
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (obs !== 13'd0) begin
      errors++;
      $display("FAIL reset: got %h expected %h", obs, 13'd0);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100;
    limite = 4'd2;
    build(2);
    start();
    for (int j = 0; j < exp_q.size(); j++) begin
      checks++;
      if (obs !== exp_q[j]) begin
        errors++;
        $display("FAIL basic cycle %0d: got %h expected %h", j, obs, exp_q[j]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_limite(input int lim);
    for (int i = 0; i < 16; i++) mem[i] = 4'(1 << (i % 4));
    if (lim == 0) mem[0] = 4'b1000;
    limite = 4'(lim);
    build(lim);
    start();
    for (int j = 0; j < exp_q.size(); j++) begin
      checks++;
      if (obs !== exp_q[j]) begin
        errors++;
        $display("FAIL limite%0d cycle %0d: got %h expected %h", lim, j, obs, exp_q[j]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_iniciar_ignored();
    mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100;
    limite = 4'd2;
    build(2);
    start();
    for (int j = 0; j < exp_q.size(); j++) begin
      checks++;
      if (obs !== exp_q[j]) begin
        errors++;
        $display("FAIL iniciar_ignored cycle %0d: got %h expected %h", j, obs, exp_q[j]);
      end
      iniciar = (j == 5);
      @(negedge clock);
    end
    iniciar = 1'b0;
  endtask

  task automatic test_abort(input bit via_reset, input int corte);
    mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100;
    limite = 4'd2;
    build(2);
    start();
    for (int j = 0; j <= corte; j++) begin
      checks++;
      if (obs !== exp_q[j]) begin
        errors++;
        $display("FAIL abort%0d pre cycle %0d: got %h expected %h", via_reset, j, obs, exp_q[j]);
      end
      if (j == corte) begin
        if (via_reset) reset = 1'b1;
        else           parar = 1'b1;
      end
      @(negedge clock);
    end
    reset = 1'b0;
    parar = 1'b0;
    for (int j = 0; j < 12; j++) begin
      checks++;
      if (obs !== 13'd0) begin
        errors++;
        $display("FAIL abort%0d idle cycle %0d: got %h expected %h", via_reset, j, obs, 13'd0);
      end
      @(negedge clock);
    end
    start();
    for (int j = 0; j < exp_q.size(); j++) begin
      checks++;
      if (obs !== exp_q[j]) begin
        errors++;
        $display("FAIL abort%0d restart cycle %0d: got %h expected %h", via_reset, j, obs, exp_q[j]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_parar_iniciar();
    parar = 1'b1;
    iniciar = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      checks++;
      if (obs !== 13'd0) begin
        errors++;
        $display("FAIL parar_iniciar cycle %0d: got %h expected %h", j, obs, 13'd0);
      end
    end
    parar = 1'b0;
    iniciar = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lim, n;
    repeat (6) begin
      lim = int'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) begin
        n = int'($urandom_range(0, 4));
        mem[i] = (n == 0) ? 4'b0000 : 4'(1 << (n - 1));
      end
      limite = 4'(lim);
      build(lim);
      start();
      for (int j = 0; j < exp_q.size() - 1; j++) begin
        checks++;
        if (obs !== exp_q[j]) begin
          errors++;
          $display("FAIL random L=%0d cycle %0d: got %h expected %h", lim, j, obs, exp_q[j]);
        end
        @(negedge clock);
      end
    end
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; parar = 1'b0; limite = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_limite(0);
    test_limite(15);
    test_iniciar_ignored();
    test_abort(1'b0, 3);
    test_abort(1'b1, 6);
    test_parar_iniciar();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
